// File: rtl/led_frame_sequencer_pkg.sv
// led_pkg: shared types and default sizing for the LED frame sequencer.
// Holds the FSM state enum, default frame geometry and the GRB pixel type.
package led_pkg;

  localparam int unsigned DEF_NUM_LEDS     = 64;
  localparam int unsigned DEF_COL_LEN      = 8;
  localparam int unsigned DEF_LATCH_CYCLES = 2000;

  typedef logic [23:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    LATCH
  } state_t;

endpackage

// File: rtl/led_frame_sequencer_if.sv
// Pixel stream from the sequencer to the bit serializer.
// master: drives ser_data/ser_valid, samples ser_ready; slave is the mirror.
interface led_frame_sequencer_if;
  import led_pkg::*;

  pixel_t ser_data;
  logic   ser_valid;
  logic   ser_ready;

  modport master (
    output ser_data,
    output ser_valid,
    input  ser_ready
  );

  modport slave (
    input  ser_data,
    input  ser_valid,
    output ser_ready
  );

endinterface

// File: rtl/led_frame_sequencer_addr_gen.sv
// led_addr_gen: maps the pixel index to a frame-buffer address.
// Ports: index (in), pix_addr (out), purely combinational.
// Build macro LED_SERPENTINE_EN selects the zig-zag column layout.
module led_addr_gen
  import led_pkg::*;
#(
  parameter int unsigned NUM_LEDS = DEF_NUM_LEDS,
  parameter int unsigned COL_LEN  = DEF_COL_LEN
) (
  input  logic [$clog2(NUM_LEDS)-1:0] index,
  output logic [$clog2(NUM_LEDS)-1:0] pix_addr
);

  localparam int unsigned AW = $clog2(NUM_LEDS);

`ifdef LED_SERPENTINE_EN
  logic [31:0] ix;
  logic [31:0] col;
  logic [31:0] pos;
  logic [31:0] addr;

  // Odd columns run bottom-up, so the in-column offset is mirrored.
  always_comb begin
    ix   = 32'(index);
    col  = ix / COL_LEN;
    pos  = ix % COL_LEN;
    addr = col * COL_LEN;
    if (col[0]) begin
      addr = addr + (COL_LEN - 1 - pos);
    end else begin
      addr = addr + pos;
    end
    pix_addr = AW'(addr);
  end
`else
  assign pix_addr = index;
`endif

endmodule

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: fetches a frame of GRB pixels and streams them out,
// then holds the line low for the latch interval.
// Ports: clk, reset (sync, active-high), start, busy, frame_done,
//   pix_addr/pix_data (buffer read, 1-cycle latency), ser (stream master).
// Optional macro LED_SERPENTINE_EN: zig-zag address mapping in led_addr_gen.
module led_frame_sequencer
  import led_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = DEF_NUM_LEDS,
  parameter int unsigned COL_LEN      = DEF_COL_LEN,
  parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        frame_done,
  output logic [$clog2(NUM_LEDS)-1:0] pix_addr,
  input  pixel_t                      pix_data,
  led_frame_sequencer_if.master       ser
);

  localparam int unsigned AW = $clog2(NUM_LEDS);
  localparam int unsigned LW = $clog2(LATCH_CYCLES + 1);

  localparam logic [AW-1:0] IDX_LAST = AW'(NUM_LEDS - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYCLES - 1);

  state_t          state;
  logic [AW-1:0]   idx;
  logic [LW-1:0]   lcnt;
  logic [LW-1:0]   lcnt_inc;
  logic            pend;
  pixel_t          data_q;
  logic            done_q;
  logic            lat_end;

  led_addr_gen #(
    .NUM_LEDS (NUM_LEDS),
    .COL_LEN  (COL_LEN)
  ) u_addr (
    .index    (idx),
    .pix_addr (pix_addr)
  );

  assign lcnt_inc      = lcnt + LW'(1);
  assign lat_end       = (state == LATCH) && (lcnt == LAT_LAST);
  assign busy          = (state != IDLE);
  assign frame_done    = done_q;
  assign ser.ser_data  = data_q;
  assign ser.ser_valid = (state == SEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      lcnt   <= '0;
      pend   <= 1'b0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // One-deep request memory; the latch-exit branch below clears it.
      if (start && state != IDLE) begin
        pend <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          data_q <= pix_data;
          state  <= SEND;
        end
        SEND: begin
          if (ser.ser_ready) begin
            if (idx == IDX_LAST) begin
              lcnt   <= '0;
              done_q <= (LATCH_CYCLES == 1);
              state  <= LATCH;
            end else begin
              idx   <= idx + AW'(1);
              state <= FETCH;
            end
          end
        end
        LATCH: begin
          if (lat_end) begin
            // A start on this very cycle restarts just like a pending one.
            if (pend || start) begin
              pend  <= 1'b0;
              idx   <= '0;
              state <= FETCH;
            end else begin
              state <= IDLE;
            end
          end else begin
            lcnt   <= lcnt_inc;
            // Registered pulse lands on the final latch count.
            done_q <= (lcnt_inc == LAT_LAST);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/led_frame_sequencer.md
LED_FRAME_SEQUENCER -- requirements
Module: led_frame_sequencer

Interface
REQ-001 Parameter NUM_LEDS, default 64, number of pixels in one frame (2..256).
REQ-002 Parameter COL_LEN, default 8, pixels per strip column; NUM_LEDS is a multiple of COL_LEN.
REQ-003 Parameter LATCH_CYCLES, default 2000, clk cycles of low line after the last pixel (50 us at 40 MHz).
REQ-004 clk  input  1  single system clock; all logic is on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to transmit one frame.
REQ-007 busy  output  1  high from frame acceptance until the end of LATCH.
REQ-008 frame_done  output  1  one-cycle pulse at the end of the latch interval.
REQ-009 pix_addr  output  $clog2(NUM_LEDS)  frame-buffer read address.
REQ-010 pix_data  input  24  frame-buffer read data, valid exactly one cycle after pix_addr.
REQ-011 ser_data  output  24  GRB pixel word to the bit serializer.
REQ-012 ser_valid  output  1  ser_data holds a pixel awaiting acceptance.
REQ-013 ser_ready  input  1  the serializer accepts the word when ser_valid && ser_ready.

Function
REQ-014 The FSM has states IDLE, FETCH, LOAD, SEND and LATCH.
REQ-015 IDLE: start=1 clears the pixel index to 0 and moves to FETCH.
REQ-016 FETCH: pix_addr is driven from the index; the FSM moves to LOAD unconditionally.
REQ-017 LOAD: pix_data is registered into ser_data; the FSM moves to SEND.
REQ-018 SEND: ser_valid=1; ser_data is held stable until ser_valid && ser_ready.
REQ-019 On handshake in SEND: if index==NUM_LEDS-1, go to LATCH; otherwise increment the index and go to FETCH.
REQ-020 ser_valid is 1 only in SEND; latency is 3 cycles from start (IDLE) to the first ser_valid.
REQ-021 LATCH: the latch counter counts 0..LATCH_CYCLES-1; on the final count, frame_done=1 for that cycle and the FSM leaves LATCH.
REQ-022 start while busy sets a one-deep pending flag; further starts are dropped.
REQ-023 On LATCH exit, if pending=1, clear pending, reset the index and go to FETCH (busy stays high); otherwise go to IDLE.
REQ-024 start on the same cycle as LATCH exit counts as pending and restarts immediately.
REQ-025 The index never exceeds NUM_LEDS-1; no wrap occurs within a frame.
REQ-026 pix_addr holds its last value outside FETCH/LOAD.
REQ-027 busy = (state != IDLE).

Reset
REQ-028 reset takes priority over all inputs and returns the FSM to IDLE on the next edge, including mid-frame and mid-latch.
REQ-029 Reset values: busy=0, frame_done=0, ser_valid=0, ser_data=0, pix_addr=0, index=0, latch counter=0, pending=0.

Configuration
REQ-030 With macro LED_SERPENTINE_EN defined, pix_addr = c*COL_LEN + (c odd ? COL_LEN-1-p : p), where c = index / COL_LEN and p = index % COL_LEN.
REQ-031 Without LED_SERPENTINE_EN, pix_addr = index.

Structure
REQ-032 Package led_pkg holds the state enum type, the default constants (NUM_LEDS, COL_LEN, LATCH_CYCLES) and the 24-bit pixel typedef.
REQ-033 Sub-module led_addr_gen (index in, pix_addr out, combinational) contains the REQ-030/031 mapping.

Verification
REQ-034 reset, then start with ser_ready held at 1 -> ser_valid first at start+3 cycles; 64 words sent; frame_done pulses once, LATCH_CYCLES cycles after the last handshake; busy=0 the following cycle.
REQ-035 Buffer word i = {8'h00, 16'(i)} with ser_ready toggling every 3 cycles -> ser_data is stable while stalled; words are received in order 0..63 (no macro).
REQ-036 With LED_SERPENTINE_EN, COL_LEN=8 -> pix_addr sequence 0..7, 15..8, 16..23, 31..24, ...
REQ-037 Two starts during frame 1 -> exactly one extra frame follows; frame_done pulses twice total.
REQ-038 reset asserted at pixel 20 while ser_valid=1 -> ser_valid=0 and busy=0 on the next cycle; no frame_done; a new start begins at index 0.
REQ-039 start coincident with the LATCH exit cycle -> FETCH follows directly and busy never drops.
